// File: rtl/mult_ctrl.sv
// -----------------------------------------------------------------------------
// mult_ctrl
//   Control unit for a shift-add multiplier. Sequences the ACC register
//   through one multiply: a parallel load, then for each multiplier bit an
//   optional add followed by a mandatory right shift. After N iterations it
//   raises done and waits for start to drop before going idle again.
//
//   Parameters
//     N    operand width in bits = number of add/shift iterations
//     CW   iteration counter width (2**CW must be >= N)
//
//   Ports
//     clk    in   rising-edge system clock
//     rst_n  in   asynchronous active-low reset
//     start  in   multiply request (level), honoured in IDLE and DONE
//     m      in   current multiplier LSB from ACC, looked at in CHECK only
//     load   out  ACC parallel-load strobe
//     sh     out  ACC right-shift strobe
//     ad     out  ACC add strobe
//     busy   out  high in every state except IDLE and DONE
//     done   out  multiply complete, held until start is low
//     cnt    out  number of bits already processed (0..N-1)
//
//   All outputs are registers loaded from the next-state decode, so they
//   are pure functions of the current state and never see start or m
//   combinationally.
// -----------------------------------------------------------------------------
module mult_ctrl #(
    parameter int N  = 8,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          m,
    output logic          load,
    output logic          sh,
    output logic          ad,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_ADD   = 3'd3,
        S_SHIFT = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_t        state_r;
    state_t        state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;

    // Output pattern {load, sh, ad, busy, done} for a given state.
    // Exactly one strobe at most per state, so the strobes are never two-hot.
    function automatic logic [4:0] decode_outputs(input state_t s);
        logic [4:0] o;
        o = 5'b00000;
        case (s)
            S_IDLE:  o = 5'b00000;
            S_LOAD:  o = 5'b10010;
            S_CHECK: o = 5'b00010;
            S_ADD:   o = 5'b00110;
            S_SHIFT: o = 5'b01010;
            S_DONE:  o = 5'b00001;
            default: o = 5'b00000;
        endcase
        return o;
    endfunction

    // Next-state and next-count logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_nxt_s = S_LOAD;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_LOAD: begin
                cnt_nxt_s   = CNT_ZERO;
                state_nxt_s = S_CHECK;
            end
            S_CHECK: begin
                if (m) begin
                    state_nxt_s = S_ADD;
                end else begin
                    state_nxt_s = S_SHIFT;
                end
            end
            S_ADD: begin
                state_nxt_s = S_SHIFT;
            end
            S_SHIFT: begin
                // The last shift keeps cnt at N-1 so it never wraps, even
                // when the counter is wider than needed.
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = S_DONE;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                    state_nxt_s = S_CHECK;
                end
            end
            S_DONE: begin
                // A held start does not re-trigger; a fresh 0->1 is needed.
                if (start) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and registered Moore outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r                    <= S_IDLE;
            cnt_r                      <= CNT_ZERO;
            {load, sh, ad, busy, done} <= 5'b00000;
        end else begin
            state_r                    <= state_nxt_s;
            cnt_r                      <= cnt_nxt_s;
            {load, sh, ad, busy, done} <= decode_outputs(state_nxt_s);
        end
    end

    assign cnt = cnt_r;

endmodule

// File: tb/tb_mult_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mult_ctrl
//   Scoreboard bench for mult_ctrl. The stimulus process issues multiplies and
//   pushes the expected outcome of each one (strobe counts, add positions,
//   latency, done duration) into a queue. A monitor process watches the DUT
//   outputs, summarises every operation from load to the fall of done, and
//   pops/compares. A third process plays the part of ACC's multiplier half to
//   drive m, and scrambles m whenever the controller is not in its check step.
// -----------------------------------------------------------------------------
module tb_mult_ctrl;

    localparam int N  = 8;
    localparam int CW = 3;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          m     = 1'b0;
    logic          load;
    logic          sh;
    logic          ad;
    logic          busy;
    logic          done;
    logic [CW-1:0] cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         k;
        logic [7:0] mask;
        int         lat;
        int         done_cyc;
    } exp_t;

    exp_t exp_q[$];

    // m driver state: 0 = always 0, 1 = always 1, 2 = follow multiplier model
    int         m_mode   = 0;
    logic [7:0] cur_mult = 8'h00;
    logic [7:0] acc_lo   = 8'h00;

    mult_ctrl #(.N(N), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .m     (m),
        .load  (load),
        .sh    (sh),
        .ad    (ad),
        .busy  (busy),
        .done  (done),
        .cnt   (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Multiplier half of ACC: loaded on load, shifted on sh. In the check
    // step (busy with no strobe) m carries the true LSB; otherwise noise.
    initial begin
        forever begin
            @(negedge clk);
            if (load) begin
                acc_lo = cur_mult;
            end else if (sh) begin
                acc_lo = acc_lo >> 1;
            end
            if (m_mode == 0) begin
                m = 1'b0;
            end else if (m_mode == 1) begin
                m = 1'b1;
            end else if (busy && !load && !sh && !ad) begin
                m = acc_lo[0];
            end else begin
                m = 1'($urandom);
            end
        end
    end

    // Monitor: summarise one operation from load until done falls.
    int         mon_active = 0;
    int         cyc, n_load, n_sh, n_ad, n_busy, done_seen, lat_seen, cnt_at_done;
    int         two_hot, ad_nosh, prev_ad;
    logic [7:0] mask_seen;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_active = 0;
            end else begin
                if (load && mon_active == 0) begin
                    mon_active = 1;
                    cyc = 0; n_load = 0; n_sh = 0; n_ad = 0; n_busy = 0;
                    done_seen = 0; lat_seen = -1; cnt_at_done = -1;
                    two_hot = 0; ad_nosh = 0; prev_ad = 0; mask_seen = 8'h00;
                end
                if (mon_active != 0) begin
                    if (int'(load) + int'(sh) + int'(ad) > 1) two_hot = 1;
                    if (prev_ad != 0 && !sh) ad_nosh = 1;
                    prev_ad = int'(ad);
                    n_load += int'(load);
                    n_sh   += int'(sh);
                    n_busy += int'(busy);
                    if (ad) begin
                        n_ad++;
                        mask_seen[cnt] = 1'b1;
                    end
                    if (done) begin
                        if (done_seen == 0) begin
                            lat_seen    = cyc;
                            cnt_at_done = int'(cnt);
                        end
                        done_seen++;
                    end else if (done_seen > 0) begin
                        mon_active = 0;
                        if (exp_q.size() == 0) begin
                            chk("unexpected_op", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("load_count",  n_load, 1);
                            chk("shift_count", n_sh, N);
                            chk("add_count",   n_ad, e.k);
                            chk("add_iters",   int'(mask_seen), int'(e.mask));
                            chk("latency",     lat_seen, e.lat);
                            chk("busy_cycles", n_busy, e.lat);
                            chk("done_cycles", done_seen, e.done_cyc);
                            chk("cnt_at_done", cnt_at_done, N - 1);
                            chk("two_hot",     two_hot, 0);
                            chk("add_then_sh", ad_nosh, 0);
                        end
                    end
                    cyc++;
                end
            end
        end
    end

    // start_mode: 0 = one-cycle pulse, 1 = held until done plus `hold` cycles,
    // 2 = held until cnt reaches drop_cnt while busy.
    task automatic run_op(input logic [7:0] mult, input int md,
                          input int start_mode, input int hold, input int drop_cnt);
        exp_t e;
        int   guard;
        cur_mult   = mult;
        m_mode     = md;
        e.mask     = (md == 0) ? 8'h00 : ((md == 1) ? 8'hFF : mult);
        e.k        = $countones(e.mask);
        e.lat      = 1 + 2 * N + e.k;
        e.done_cyc = (start_mode == 1) ? 1 + hold : 1;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        if (start_mode == 0) start = 1'b0;
        guard = 0;
        while (!done && guard < 200) begin
            if (start_mode == 2 && busy && int'(cnt) == drop_cnt) start = 1'b0;
            @(negedge clk);
            guard++;
        end
        if (!done) chk("done_timeout", 0, 1);
        for (int i = 0; i < hold && start_mode == 1; i++) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int guard;
        #1 rst_n = 1'b0;
        #2 chk("reset_outputs", int'({load, sh, ad, busy, done, cnt}), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_start", int'({load, busy, done}), 0);

        run_op(8'h00, 0, 0, 0, -1);          // all-zero m stream, 17 edges
        run_op(8'hAC, 2, 0, 0, -1);          // adds at cnt 2,3,5,7, 21 edges
        run_op(8'h00, 1, 0, 0, -1);          // m forced 1, 25 edges
        run_op(8'($urandom), 2, 1, 5, -1);   // start held 5 cycles into DONE
        run_op(8'($urandom), 2, 2, 0, 3);    // start dropped at cnt=3
        for (int i = 0; i < 10; i++) begin
            run_op(8'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                   $urandom_range(0, 4), $urandom_range(1, 6));
        end

        // Reset while in ADD: outputs clear at once, no restart without a new start.
        cur_mult = 8'h00;
        m_mode   = 1;
        @(negedge clk);
        start = 1'b1;
        guard = 0;
        while (!ad && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("reach_add", int'(ad), 1);
        #2 rst_n = 1'b0;
        start = 1'b0;
        #1 chk("mid_op_reset", int'({load, sh, ad, busy, done, cnt}), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_after_reset", int'({load, sh, ad, busy, done}), 0);
        end
        run_op(8'h5A, 2, 0, 0, -1);

        repeat (4) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
